// File: rtl/scr1_tb_trace_pkg.sv
// rtl/scr1_tb_trace_pkg.sv - trace record type, capture state and widths for the trace buffer
`ifndef SCR1_XLEN
`define SCR1_XLEN 32
`endif

package scr1_tb_trace_pkg;

  localparam int SCR1_TRACE_DROP_W       = 16;
  localparam int SCR1_TRACE_SEQ_W        = 16;
  localparam int SCR1_CSR_COUNTERS_WIDTH = 64;

  typedef enum logic {
    SCR1_TRACE_RUN    = 1'b0,
    SCR1_TRACE_FROZEN = 1'b1
  } type_scr1_trace_state_e;

  typedef struct packed {
    logic [SCR1_TRACE_SEQ_W-1:0]        seq;
    logic [1:0]                         rule_hit;
    logic [31:0]                        instr;
    logic [`SCR1_XLEN-1:0]              pc;
    logic [SCR1_CSR_COUNTERS_WIDTH-1:0] mcycle;
    logic [`SCR1_XLEN-1:0]              mstatus;
  } type_scr1_trace_rec_s;

  function automatic logic rule_match(input logic [31:0] instr,
                                      input logic [31:0] mask,
                                      input logic [31:0] val);
    return (instr & mask) == val;
  endfunction

endpackage

// File: rtl/scr1_tb_instr_trace_buf_if.sv
// rtl/scr1_tb_instr_trace_buf_if.sv - record drain handshake between trace buffer and logger
`ifndef SCR1_XLEN
`define SCR1_XLEN 32
`endif

interface scr1_tb_instr_trace_buf_if;
  import scr1_tb_trace_pkg::*;

  logic                 rec_vd;
  logic                 rec_rdy;
  type_scr1_trace_rec_s rec;

  modport master (output rec_vd, output rec, input rec_rdy);
  modport slave  (input rec_vd, input rec, output rec_rdy);

endinterface

// File: rtl/scr1_tb_trace_fifo.sv
// rtl/scr1_tb_trace_fifo.sv - synchronous record FIFO with wrap-bit pointers
module scr1_tb_trace_fifo
  import scr1_tb_trace_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  type_scr1_trace_rec_s     wdata,
  output type_scr1_trace_rec_s     rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   cnt
);

  localparam int AW = $clog2(DEPTH);

  type_scr1_trace_rec_s mem [DEPTH];
  logic [AW:0]          wr_ptr;
  logic [AW:0]          rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage is not reset; contents behind the pointers are don't-care.
  always_ff @(posedge clk) begin
    if (push && !clr) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign cnt   = wr_ptr - rd_ptr;
  assign rdata = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/scr1_tb_instr_trace_buf.sv
// rtl/scr1_tb_instr_trace_buf.sv - instruction match, snapshot and buffering ahead of the logger
`ifndef SCR1_XLEN
`define SCR1_XLEN 32
`endif

module scr1_tb_instr_trace_buf
  import scr1_tb_trace_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int SEQ_W        = 16,
  parameter bit STOP_ON_FULL = 1'b0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               clr,
  input  logic                               trace_en,
  input  logic                               instr_vd,
  input  logic [31:0]                        instr,
  input  logic [`SCR1_XLEN-1:0]              pc,
  input  logic [SCR1_CSR_COUNTERS_WIDTH-1:0] mcycle,
  input  logic [`SCR1_XLEN-1:0]              mstatus,
  input  logic [1:0]                         rule_en,
  input  logic [31:0]                        rule0_mask,
  input  logic [31:0]                        rule0_val,
  input  logic [31:0]                        rule1_mask,
  input  logic [31:0]                        rule1_val,
  scr1_tb_instr_trace_buf_if.master          rec_if,
  output logic [$clog2(DEPTH):0]             fifo_cnt,
  output logic [SCR1_TRACE_DROP_W-1:0]       drop_cnt,
  output logic                               overflow
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [1:0]             hit;
  logic                   capture;
  logic                   push;
  logic                   pop;
  logic                   full;
  logic                   empty;
  logic [SEQ_W-1:0]       seq;
  type_scr1_trace_state_e state;
  type_scr1_trace_rec_s   wr_rec;
  type_scr1_trace_rec_s   rd_rec;

  assign hit[0]  = rule_en[0] & rule_match(instr, rule0_mask, rule0_val);
  assign hit[1]  = rule_en[1] & rule_match(instr, rule1_mask, rule1_val);
  assign capture = trace_en & instr_vd & (|hit) & (state == SCR1_TRACE_RUN);
  assign pop     = ~empty & rec_if.rec_rdy;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign push    = capture & (~full | pop);

  always_comb begin
    wr_rec          = '0;
    wr_rec.seq      = SCR1_TRACE_SEQ_W'(seq);
    wr_rec.rule_hit = hit;
    wr_rec.instr    = instr;
    wr_rec.pc       = pc;
    wr_rec.mcycle   = mcycle;
    wr_rec.mstatus  = mstatus;
  end

  scr1_tb_trace_fifo #(.DEPTH(DEPTH)) i_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .push  (push),
    .pop   (pop),
    .wdata (wr_rec),
    .rdata (rd_rec),
    .full  (full),
    .empty (empty),
    .cnt   (fifo_cnt)
  );

  assign rec_if.rec_vd = ~empty;
  assign rec_if.rec    = rd_rec;

  // seq counts every capture attempt so the logger sees gaps where hits were dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq      <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else if (clr) begin
      seq      <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (capture) seq <= seq + SEQ_W'(1);
      if (capture && !push) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + SCR1_TRACE_DROP_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SCR1_TRACE_RUN;
    end else if (clr || !STOP_ON_FULL) begin
      state <= SCR1_TRACE_RUN;
    end else begin
      case (state)
        SCR1_TRACE_RUN:
          if (push && !pop && fifo_cnt == CW'(DEPTH - 1)) state <= SCR1_TRACE_FROZEN;
        SCR1_TRACE_FROZEN:
          if (fifo_cnt == '0 || (pop && fifo_cnt == CW'(1))) state <= SCR1_TRACE_RUN;
        default:
          state <= SCR1_TRACE_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_scr1_tb_instr_trace_buf.sv
// tb/tb_scr1_tb_instr_trace_buf.sv - scoreboard bench for the instruction trace buffer
`ifndef SCR1_XLEN
`define SCR1_XLEN 32
`endif

module tb_scr1_tb_instr_trace_buf;
  import scr1_tb_trace_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        te0 = 1'b0;
  logic        te1 = 1'b0;
  logic        instr_vd = 1'b0;
  logic [31:0] instr = '0;
  logic [`SCR1_XLEN-1:0] pc = '0;
  logic [`SCR1_XLEN-1:0] mstatus = '0;
  logic [SCR1_CSR_COUNTERS_WIDTH-1:0] mcycle = '0;
  logic [1:0]  rule_en = 2'b11;
  logic [31:0] r0m = 32'h0000_007F;
  logic [31:0] r0v = 32'h0000_0033;
  logic [31:0] r1m = 32'h0000_7000;
  logic [31:0] r1v = 32'h0000_6000;

  logic [3:0]  cnt0, cnt1;
  logic [15:0] drop0, drop1;
  logic        ovf0, ovf1;

  int checks = 0;
  int passed = 0;
  type_scr1_trace_rec_s exp0[$];
  type_scr1_trace_rec_s exp1[$];

  scr1_tb_instr_trace_buf_if if0();
  scr1_tb_instr_trace_buf_if if1();

  scr1_tb_instr_trace_buf #(.DEPTH(8), .SEQ_W(16), .STOP_ON_FULL(1'b0)) dut0 (
    .clk(clk), .rst(rst), .clr(clr), .trace_en(te0), .instr_vd(instr_vd),
    .instr(instr), .pc(pc), .mcycle(mcycle), .mstatus(mstatus), .rule_en(rule_en),
    .rule0_mask(r0m), .rule0_val(r0v), .rule1_mask(r1m), .rule1_val(r1v),
    .rec_if(if0), .fifo_cnt(cnt0), .drop_cnt(drop0), .overflow(ovf0)
  );

  scr1_tb_instr_trace_buf #(.DEPTH(8), .SEQ_W(16), .STOP_ON_FULL(1'b1)) dut1 (
    .clk(clk), .rst(rst), .clr(clr), .trace_en(te1), .instr_vd(instr_vd),
    .instr(instr), .pc(pc), .mcycle(mcycle), .mstatus(mstatus), .rule_en(rule_en),
    .rule0_mask(r0m), .rule0_val(r0v), .rule1_mask(r1m), .rule1_val(r1v),
    .rec_if(if1), .fifo_cnt(cnt1), .drop_cnt(drop1), .overflow(ovf1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_rec(input string name, input type_scr1_trace_rec_s act,
                         input type_scr1_trace_rec_s exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got seq=%0d hit=%b instr=%h pc=%h mcycle=%h mstatus=%h expected seq=%0d hit=%b instr=%h pc=%h mcycle=%h mstatus=%h",
                  name, act.seq, act.rule_hit, act.instr, act.pc, act.mcycle, act.mstatus,
                  exp.seq, exp.rule_hit, exp.instr, exp.pc, exp.mcycle, exp.mstatus);
  endtask

  function automatic type_scr1_trace_rec_s mk(input int s, input logic [1:0] h,
                                              input logic [31:0] ins, input logic [31:0] p);
    type_scr1_trace_rec_s r;
    r.seq      = 16'(s);
    r.rule_hit = h;
    r.instr    = ins;
    r.pc       = p;
    r.mcycle   = {32'hC0DE_0000, p};
    r.mstatus  = 32'h0000_1800 | p;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic hit_cycle(input logic [31:0] ins, input logic [31:0] p);
    instr_vd = 1'b1;
    instr    = ins;
    pc       = p;
    mcycle   = {32'hC0DE_0000, p};
    mstatus  = 32'h0000_1800 | p;
    step();
  endtask

  always @(negedge clk) begin
    if (!rst && if0.rec_vd && if0.rec_rdy) begin
      if (exp0.size() == 0) begin
        checks++;
        $display("FAIL dut0_unexpected_rec: got seq %0d expected none", if0.rec.seq);
      end else chk_rec("dut0_rec", if0.rec, exp0.pop_front());
    end
    if (!rst && if1.rec_vd && if1.rec_rdy) begin
      if (exp1.size() == 0) begin
        checks++;
        $display("FAIL dut1_unexpected_rec: got seq %0d expected none", if1.rec.seq);
      end else chk_rec("dut1_rec", if1.rec, exp1.pop_front());
    end
  end

  initial begin
    if0.rec_rdy = 1'b0;
    if1.rec_rdy = 1'b0;
    step();
    chk("rst_rec_vd0", if0.rec_vd, 0);
    chk("rst_cnt0", cnt0, 0);
    chk("rst_drop0", drop0, 0);
    chk("rst_ovf0", ovf0, 0);
    chk("rst_rec_vd1", if1.rec_vd, 0);
    step();
    rst = 1'b0;
    step();

    // single hit, latency, no bypass
    te0 = 1'b1;
    exp0.push_back(mk(0, 2'b11, 32'h0020E1B3, 32'h200));
    instr_vd = 1'b1; instr = 32'h0020E1B3;
    #1;
    chk("no_bypass_rec_vd", if0.rec_vd, 0);
    hit_cycle(32'h0020E1B3, 32'h200);
    instr_vd = 1'b0;
    chk("lat_rec_vd", if0.rec_vd, 1);
    chk("lat_cnt", cnt0, 1);
    hit_cycle(32'h0000_0013, 32'h204);
    instr_vd = 1'b0;
    chk("nomatch_cnt", cnt0, 1);
    if0.rec_rdy = 1'b1;
    step();
    chk("drain1_cnt", cnt0, 0);

    // rule patterns, trace_en gating, rule_en gating
    exp0.push_back(mk(1, 2'b01, 32'h0000_0033, 32'h208));
    hit_cycle(32'h0000_0033, 32'h208);
    te0 = 1'b0;
    hit_cycle(32'h0020E1B3, 32'h20C);
    te0 = 1'b1;
    chk("te_off_cnt", cnt0, 0);
    rule_en = 2'b10;
    exp0.push_back(mk(2, 2'b10, 32'h0020E1B3, 32'h210));
    hit_cycle(32'h0020E1B3, 32'h210);
    rule_en = 2'b11;
    exp0.push_back(mk(3, 2'b10, 32'h0000_6003, 32'h214));
    hit_cycle(32'h0000_6003, 32'h214);
    instr_vd = 1'b0;
    step(); step();
    chk("t1_queue_empty", exp0.size(), 0);

    // overflow without freeze
    clr = 1'b1; step(); clr = 1'b0;
    chk("clr_cnt", cnt0, 0);
    if0.rec_rdy = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k < 8) exp0.push_back(mk(k, 2'b11, 32'h0020E1B3, 32'h300 + 4 * k));
      hit_cycle(32'h0020E1B3, 32'h300 + 4 * k);
    end
    instr_vd = 1'b0;
    chk("ovf_cnt", cnt0, 8);
    chk("ovf_drop", drop0, 2);
    chk("ovf_flag", ovf0, 1);

    // full with concurrent pop and push
    if0.rec_rdy = 1'b1;
    exp0.push_back(mk(10, 2'b01, 32'h0000_0033, 32'h400));
    hit_cycle(32'h0000_0033, 32'h400);
    instr_vd = 1'b0;
    chk("fullpp_cnt", cnt0, 8);
    chk("fullpp_drop", drop0, 2);
    repeat (10) step();
    chk("ovf_drain_cnt", cnt0, 0);
    chk("ovf_queue_empty", exp0.size(), 0);
    if0.rec_rdy = 1'b0;

    // freeze on full
    te0 = 1'b0;
    te1 = 1'b1;
    for (int k = 0; k < 11; k++) begin
      if (k < 8) exp1.push_back(mk(k, 2'b11, 32'h0020E1B3, 32'h500 + 4 * k));
      hit_cycle(32'h0020E1B3, 32'h500 + 4 * k);
    end
    instr_vd = 1'b0;
    chk("frz_cnt", cnt1, 8);
    chk("frz_drop", drop1, 0);
    chk("frz_ovf", ovf1, 0);
    if1.rec_rdy = 1'b1;
    repeat (8) step();
    chk("frz_drain_cnt", cnt1, 0);
    exp1.push_back(mk(8, 2'b11, 32'h0020E1B3, 32'h600));
    hit_cycle(32'h0020E1B3, 32'h600);
    instr_vd = 1'b0;
    step(); step();
    chk("frz_queue_empty", exp1.size(), 0);
    te1 = 1'b0;

    // async reset mid-stream
    te0 = 1'b1;
    for (int k = 0; k < 5; k++) hit_cycle(32'h0020E1B3, 32'h700 + 4 * k);
    instr_vd = 1'b0;
    chk("pre_rst_cnt", cnt0, 5);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_rec_vd", if0.rec_vd, 0);
    chk("arst_cnt", cnt0, 0);
    chk("arst_drop", drop0, 0);
    chk("arst_ovf", ovf0, 0);
    step();
    rst = 1'b0;
    exp0.push_back(mk(0, 2'b01, 32'h0000_0033, 32'h800));
    hit_cycle(32'h0000_0033, 32'h800);
    instr_vd = 1'b0;
    if0.rec_rdy = 1'b1;
    step(); step();
    chk("arst_queue_empty", exp0.size(), 0);

    // clr with same-cycle hit
    if0.rec_rdy = 1'b0;
    hit_cycle(32'h0020E1B3, 32'h900);
    hit_cycle(32'h0020E1B3, 32'h904);
    clr = 1'b1;
    hit_cycle(32'h0020E1B3, 32'h908);
    clr = 1'b0;
    instr_vd = 1'b0;
    chk("clr_hit_cnt", cnt0, 0);
    chk("clr_hit_rec_vd", if0.rec_vd, 0);
    exp0.push_back(mk(0, 2'b11, 32'h0020E1B3, 32'hA00));
    hit_cycle(32'h0020E1B3, 32'hA00);
    instr_vd = 1'b0;
    if0.rec_rdy = 1'b1;
    step(); step();
    chk("clr_queue_empty", exp0.size(), 0);
    chk("end_cnt0", cnt0, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
